// File: rtl/cpu_multicycle_core.sv
// Multi-cycle 10-bit-ISA core with req/ack instruction and data memory ports.
// Optional performance counters are enabled by defining PERF_CNT_EN.
module cpu_multicycle_core #(
  parameter int unsigned DW     = 10,
  parameter int unsigned AW     = 10,
  parameter int unsigned RST_PC = 0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [9:0]    imem_rdata,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ack,
  input  logic [DW-1:0] dmem_rdata,
  output logic          halted,
  output logic [AW-1:0] pc_out,
  output logic [31:0]   cyc_cnt,
  output logic [31:0]   ret_cnt
);

  typedef enum logic [1:0] {StFetch, StExec, StMem, StHalt} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] maddr_q, maddr_d;
  logic [9:0]    ir_q, ir_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          halted_q, halted_d;
  logic [DW-1:0] rf_q [8];
  logic [DW-1:0] rf_d [8];

  logic [2:0]    op;
  logic [1:0]    rs, rt, imm;
  logic          bank;
  logic [2:0]    rs_idx, rt_idx;
  logic [DW-1:0] ra, rb, alu_res, imm_sext;
  logic [AW-1:0] pc_inc, pc_br;

  assign op       = ir_q[9:7];
  assign rs       = ir_q[6:5];
  assign rt       = ir_q[4:3];
  assign bank     = ir_q[2];
  assign imm      = ir_q[1:0];
  assign rs_idx   = {bank, rs};
  assign rt_idx   = {bank, rt};
  assign ra       = rf_q[rs_idx];
  assign rb       = rf_q[rt_idx];
  assign imm_sext = {{(DW-2){imm[1]}}, imm};
  assign pc_inc   = pc_q + AW'(1);
  assign pc_br    = pc_q + AW'(imm);

  always_comb begin
    alu_res = '0;
    unique case (imm)
      2'b00: alu_res = ra + rb;
      2'b01: alu_res = ra - rb;
      2'b10: alu_res = ($signed(ra) < $signed(rb)) ? DW'(1) : '0;
      2'b11: alu_res = ~(ra & rb);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    maddr_d  = maddr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    halted_d = halted_q;
    rf_d     = rf_q;
    unique case (state_q)
      StFetch: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = StFetch;
        pc_d    = pc_inc;
        unique case (op)
          3'b000: rf_d[rt_idx] = alu_res;
          3'b001: begin
            unique case (imm)
              2'b00: rf_d[rt_idx] = ra >> 1;
              2'b01: rf_d[rt_idx] = ra << 1;
              2'b10: begin
                pc_d     = pc_q;
                halted_d = 1'b1;
                state_d  = StHalt;
              end
              default: ;
            endcase
          end
          3'b010: if (ra != rb) pc_d = pc_br;
          3'b011: rf_d[rt_idx] = ra + imm_sext;
          3'b100: pc_d = AW'({{AW{ir_q[6]}}, ir_q[6:0]});
          3'b101: if (ra == rb) pc_d = pc_br;
          default: begin
            // LOAD/STORE: operands frozen here so the bus stays stable during MEM
            pc_d    = pc_q;
            maddr_d = AW'(ra) + AW'(imm);
            wdata_d = rb;
            we_d    = op[0];
            state_d = StMem;
          end
        endcase
      end
      StMem: begin
        if (dmem_ack) begin
          if (!we_q) rf_d[rt_idx] = dmem_rdata;
          pc_d    = pc_inc;
          state_d = StFetch;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StFetch;
      pc_q     <= AW'(RST_PC);
      ir_q     <= '0;
      maddr_q  <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      halted_q <= 1'b0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      maddr_q  <= maddr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      halted_q <= halted_d;
      rf_q     <= rf_d;
    end
  end

  // Requests decode straight from state so reset withdraws them asynchronously
  assign imem_req   = (state_q == StFetch) & ~rst;
  assign imem_addr  = pc_q;
  assign dmem_req   = (state_q == StMem);
  assign dmem_we    = dmem_req & we_q;
  assign dmem_addr  = maddr_q;
  assign dmem_wdata = wdata_q;
  assign halted     = halted_q;
  assign pc_out     = pc_q;

`ifdef PERF_CNT_EN
  logic        retire;
  logic [31:0] cyc_cnt_q, cyc_cnt_d, ret_cnt_q, ret_cnt_d;

  assign retire = ((state_q == StExec) && (op[2:1] != 2'b11)) ||
                  ((state_q == StMem) && dmem_ack);

  always_comb begin
    cyc_cnt_d = cyc_cnt_q + {31'b0, ~halted_q};
    ret_cnt_d = ret_cnt_q + {31'b0, retire};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt_q <= '0;
      ret_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

  assign cyc_cnt = cyc_cnt_q;
  assign ret_cnt = ret_cnt_q;
`else
  assign cyc_cnt = '0;
  assign ret_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_multicycle_core.sv
// Randomized bench for cpu_multicycle_core: wait-stated memories plus an ISA-level
// reference interpreter; directed programs cover latency, branches, wrap and reset.
module tb_cpu_multicycle_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req, dmem_req, dmem_we, halted;
  logic [9:0]  imem_addr, dmem_addr, dmem_wdata, pc_out;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic [9:0]  imem_rdata = '0;
  logic [9:0]  dmem_rdata = '0;
  logic [31:0] cyc_cnt, ret_cnt;

  always #5 clk = ~clk;

  cpu_multicycle_core #(.DW(10), .AW(10), .RST_PC(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .halted     (halted),
    .pc_out     (pc_out),
    .cyc_cnt    (cyc_cnt),
    .ret_cnt    (ret_cnt)
  );

  logic [9:0] imem [1024];
  logic [9:0] dram [1024];
  int rmem [1024];
  int rreg [8];
  int rpc;
  bit r_halted;
  bit exp_mem, exp_we;
  int exp_addr, exp_wdata;
  int n_fetch, iw_min, iw_max, dw_min, dw_max, iw, dw, run_len;
  int held_q[$];
  int trace[$];
  int n_tests = 0;
  int n_fail = 0;

  localparam logic [9:0] Nop  = 10'b001_00_00_0_11;
  localparam logic [9:0] Halt = 10'b001_00_00_0_10;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] enc(input int op, input int rs, input int rt, input int b,
                                     input int imm);
    logic [9:0] w;
    w = {3'(op), 2'(rs), 2'(rt), 1'(b), 2'(imm)};
    return w;
  endfunction

  // Architectural interpreter: executes a whole instruction at fetch time.
  task automatic model_step(input logic [9:0] ins);
    int op, rs, rt, imm, b, d, a, c, npc, ea, simm, sa, sc;
    op   = int'(ins[9:7]);
    rs   = int'(ins[6:5]);
    rt   = int'(ins[4:3]);
    b    = int'(ins[2]);
    imm  = int'(ins[1:0]);
    d    = b * 4 + rt;
    a    = rreg[b * 4 + rs];
    c    = rreg[d];
    npc  = (rpc + 1) % 1024;
    ea   = (a + imm) % 1024;
    sa   = (a >= 512) ? a - 1024 : a;
    sc   = (c >= 512) ? c - 1024 : c;
    simm = (imm >= 2) ? imm - 4 : imm;
    case (op)
      0: begin
        if (imm == 0) rreg[d] = (a + c) % 1024;
        else if (imm == 1) rreg[d] = (a - c + 1024) % 1024;
        else if (imm == 2) rreg[d] = (sa < sc) ? 1 : 0;
        else rreg[d] = 1023 - (a & c);
      end
      1: begin
        if (imm == 0) rreg[d] = a / 2;
        else if (imm == 1) rreg[d] = (a * 2) % 1024;
        else if (imm == 2) begin
          r_halted = 1'b1;
          npc = rpc;
        end
      end
      2: if (a != c) npc = (rpc + imm) % 1024;
      3: rreg[d] = (a + simm + 1024) % 1024;
      4: npc = ins[6] ? int'(ins[6:0]) + 896 : int'(ins[6:0]);
      5: if (a == c) npc = (rpc + imm) % 1024;
      6: begin
        exp_mem = 1'b1; exp_we = 1'b0; exp_addr = ea;
        rreg[d] = rmem[ea];
      end
      default: begin
        exp_mem = 1'b1; exp_we = 1'b1; exp_addr = ea; exp_wdata = c;
        rmem[ea] = c;
      end
    endcase
    rpc = npc;
  endtask

  // Memory responders: act on the falling edge, the core samples on the rising edge
  always @(negedge clk) begin
    imem_ack   = 1'b0;
    dmem_ack   = 1'b0;
    imem_rdata = 10'($urandom);
    dmem_rdata = 10'($urandom);
    if (!rst && imem_req) begin
      check_eq("ifetch_addr", int'(imem_addr), rpc);
      check_eq("halted_running", int'(halted), 0);
      if (iw == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = imem[imem_addr];
        check_eq("mem_done_before_fetch", int'(exp_mem), 0);
        trace.push_back(int'(imem_addr));
        model_step(imem[imem_addr]);
        n_fetch++;
        iw = int'($urandom_range(iw_max, iw_min));
      end else iw--;
    end else imem_ack = 1'($urandom);
    if (!rst && dmem_req) begin
      check_eq("dmem_expected", int'(exp_mem), 1);
      check_eq("dmem_we", int'(dmem_we), int'(exp_we));
      check_eq("dmem_addr", int'(dmem_addr), exp_addr);
      if (exp_we) check_eq("dmem_wdata", int'(dmem_wdata), exp_wdata);
      run_len++;
      if (dw == 0) begin
        dmem_ack = 1'b1;
        if (dmem_we) dram[dmem_addr] = dmem_wdata;
        else dmem_rdata = dram[dmem_addr];
        held_q.push_back(run_len);
        run_len = 0;
        exp_mem = 1'b0;
        dw = int'($urandom_range(dw_max, dw_min));
      end else dw--;
    end else dmem_ack = 1'($urandom);
  end

  task automatic setup(input int iwmin, input int iwmax, input int dwmin, input int dwmax);
    rst = 1'b1;
    #1;
    check_eq("rst_imem_req", int'(imem_req), 0);
    check_eq("rst_dmem_req", int'(dmem_req), 0);
    check_eq("rst_dmem_we", int'(dmem_we), 0);
    check_eq("rst_halted", int'(halted), 0);
    check_eq("rst_pc", int'(pc_out), 0);
    check_eq("rst_cyc_cnt", int'(cyc_cnt), 0);
    check_eq("rst_ret_cnt", int'(ret_cnt), 0);
    iw_min = iwmin; iw_max = iwmax; dw_min = dwmin; dw_max = dwmax;
    iw = int'($urandom_range(iwmax, iwmin));
    dw = int'($urandom_range(dwmax, dwmin));
    for (int i = 0; i < 8; i++) rreg[i] = 0;
    rpc = 0; r_halted = 1'b0; exp_mem = 1'b0; n_fetch = 0; run_len = 0;
    trace.delete();
    held_q.delete();
    for (int i = 0; i < 1024; i++) begin
      imem[i] = Nop;
      dram[i] = 10'($urandom);
      rmem[i] = int'(dram[i]);
    end
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_until(input int n, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(posedge clk);
      #1;
      if (r_halted || n_fetch >= n) break;
    end
    if (k == budget) check_eq("run_timeout_fetches", n_fetch, n);
  endtask

  task automatic halt_checks();
    repeat (3) @(posedge clk);
    #1;
    check_eq("halted_set", int'(halted), 1);
    check_eq("halt_imem_req", int'(imem_req), 0);
    check_eq("halt_dmem_req", int'(dmem_req), 0);
    check_eq("halt_pc", int'(pc_out), rpc);
`ifdef PERF_CNT_EN
    check_eq("halt_ret_cnt", int'(ret_cnt), n_fetch);
`else
    check_eq("halt_ret_cnt", int'(ret_cnt), 0);
`endif
  endtask

  task automatic prog1(input int wait_n, input int halt_cycle);
    setup(wait_n, wait_n, 0, 0);
    imem[0] = enc(3, 0, 1, 0, 1);
    imem[1] = enc(0, 1, 1, 0, 0);
    imem[2] = Halt;
    release_rst();
    for (int k = 1; k <= halt_cycle; k++) begin
      @(posedge clk);
      #1;
      if (k == halt_cycle - 1) check_eq("p1_not_yet_halted", int'(halted), 0);
      if (k == halt_cycle) check_eq("p1_halted_on_time", int'(halted), 1);
    end
    check_eq("p1_pc", int'(pc_out), 2);
    repeat (5) @(posedge clk);
    #1;
`ifdef PERF_CNT_EN
    check_eq("p1_cyc_cnt", int'(cyc_cnt), halt_cycle);
    check_eq("p1_ret_cnt", int'(ret_cnt), 3);
`else
    check_eq("p1_cyc_cnt", int'(cyc_cnt), 0);
    check_eq("p1_ret_cnt", int'(ret_cnt), 0);
`endif
  endtask

  initial begin
    int saved;
    #1 rst = 1'b1;
    prog1(0, 6);
    prog1(2, 12);

    // STORE r1=5 to [2], LOAD r3, STORE r3 to [3]; each access held 3 cycles
    setup(0, 1, 2, 2);
    imem[0] = enc(3, 0, 1, 0, 1);
    imem[1] = enc(0, 1, 1, 0, 0);
    imem[2] = enc(0, 1, 1, 0, 0);
    imem[3] = enc(3, 1, 1, 0, 1);
    imem[4] = enc(7, 0, 1, 0, 2);
    imem[5] = enc(6, 0, 3, 0, 2);
    imem[6] = enc(7, 0, 3, 0, 3);
    imem[7] = Halt;
    release_rst();
    run_until(100, 300);
    halt_checks();
    check_eq("ram2_stored", int'(dram[2]), 5);
    check_eq("ram3_loaded_r3", int'(dram[3]), 5);
    check_eq("n_mem_accesses", held_q.size(), 3);
    for (int i = 0; i < held_q.size(); i++) check_eq("dmem_req_held", held_q[i], 3);

    // BEQ taken at pc=4, BNE on equal regs falls through
    setup(0, 0, 0, 0);
    imem[4] = enc(5, 0, 0, 0, 3);
    imem[7] = enc(2, 0, 0, 0, 3);
    imem[8] = Halt;
    release_rst();
    run_until(100, 300);
    halt_checks();
    check_eq("beq_trace_len", trace.size(), 7);
    if (trace.size() >= 7) begin
      check_eq("beq_target", trace[5], 7);
      check_eq("bne_fallthrough", trace[6], 8);
    end

    // JUMP to 0x3FF, then pc wraps to 0
    setup(0, 1, 0, 0);
    imem[0] = enc(4, 3, 3, 1, 3);
    release_rst();
    run_until(3, 100);
    check_eq("jump_trace_len", trace.size(), 3);
    if (trace.size() >= 3) begin
      check_eq("jump_target", trace[1], 1023);
      check_eq("pc_wrap", trace[2], 0);
    end

    // Reset while a STORE waits for its ack
    setup(0, 0, 6, 6);
    imem[0] = enc(3, 0, 1, 0, 1);
    imem[1] = enc(7, 0, 1, 0, 0);
    saved = int'(dram[0]);
    release_rst();
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      if (dmem_req) break;
    end
    check_eq("store_req_seen", int'(dmem_req), 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("abort_dmem_req", int'(dmem_req), 0);
    check_eq("abort_imem_req", int'(imem_req), 0);
    check_eq("abort_pc", int'(pc_out), 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("abort_ram_untouched", int'(dram[0]), saved);

    // Random programs against the interpreter
    for (int p = 0; p < 24; p++) begin
      setup(0, int'($urandom_range(3, 0)), 0, int'($urandom_range(3, 0)));
      for (int i = 0; i < 1024; i++) imem[i] = 10'($urandom);
      release_rst();
      run_until(60, 3000);
      if (r_halted) halt_checks();
    end

    rst = 1'b1;
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
